// File: rtl/vnu_iter_sched_fsm_pkg.sv
// Shared decoding-control definitions: scheduler state encoding and iteration-count width.
package vnu_iter_sched_fsm_pkg;

    localparam int unsigned ITER_W = 4;

    typedef enum logic [2:0] {
        StIdle,
        StInitLoad,
        StRead,
        StWaitWr,
        StIterUp,
        StDone
    } sched_state_e;

endpackage

// File: rtl/vnu_wr_watchdog.sv
// Write-acknowledge watchdog: held loaded while idle, counts down while running,
// and flags expiry on the last allowed cycle.
module vnu_wr_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic read_clk,
    input  logic rstn,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] LoadVal = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= LoadVal;
        end else if (load) begin
            cnt_q <= LoadVal;
        end else if (run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

    assign expire = run && (cnt_q == '0);

endmodule

// File: rtl/vnu_iter_sched_fsm.sv
// VNU iteration scheduler: init load, read/write-wait iterations, done/timeout handling.
// Optional early termination on zero syndrome when EARLY_TERM_EN is defined.
module vnu_iter_sched_fsm
    import vnu_iter_sched_fsm_pkg::*;
#(
    parameter int unsigned ITER_MAX   = 10,
    parameter int unsigned RD_CYCLES  = 8,
    parameter int unsigned WR_TIMEOUT = 64
) (
    input  logic              read_clk,
    input  logic              rstn,
    input  logic              decode_start_i,
`ifdef EARLY_TERM_EN
    input  logic              syndrome_zero_i,
`endif
    input  logic              vnu_wr_i,
    output logic              vnu_init_load_en_o,
    output logic              vnu_rd_finish_o,
    output logic              iter_update_o,
    output logic [ITER_W-1:0] iter_cnt_o,
    output logic              busy_o,
    output logic              decode_done_o,
    output logic              wr_timeout_o
);

    localparam logic [7:0]        RdLoad   = 8'(RD_CYCLES - 1);
    localparam logic [ITER_W-1:0] IterMaxW = ITER_W'(ITER_MAX);

    sched_state_e      state_q;
    logic [7:0]        phase_q;
    logic [ITER_W-1:0] iter_next;
    logic              wd_expire;
    logic              early_term;

    assign iter_next = iter_cnt_o + ITER_W'(1);

`ifdef EARLY_TERM_EN
    assign early_term = syndrome_zero_i;
`else
    assign early_term = 1'b0;
`endif

    vnu_wr_watchdog #(
        .TIMEOUT (WR_TIMEOUT)
    ) u_wr_watchdog (
        .read_clk (read_clk),
        .rstn     (rstn),
        .load     (state_q != StWaitWr),
        .run      (state_q == StWaitWr),
        .expire   (wd_expire)
    );

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            state_q            <= StIdle;
            phase_q            <= '0;
            vnu_init_load_en_o <= 1'b0;
            vnu_rd_finish_o    <= 1'b0;
            iter_update_o      <= 1'b0;
            iter_cnt_o         <= '0;
            busy_o             <= 1'b0;
            decode_done_o      <= 1'b0;
            wr_timeout_o       <= 1'b0;
        end else begin
            decode_done_o <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (decode_start_i) begin
                        state_q            <= StInitLoad;
                        phase_q            <= RdLoad;
                        iter_cnt_o         <= '0;
                        wr_timeout_o       <= 1'b0;
                        vnu_init_load_en_o <= 1'b1;
                        busy_o             <= 1'b1;
                    end
                end
                // Load enable stays high into WAIT_WR until the write returns.
                StInitLoad: begin
                    if (phase_q == '0) begin
                        state_q <= StWaitWr;
                    end else begin
                        phase_q <= phase_q - 8'd1;
                    end
                end
                StRead: begin
                    if (phase_q == '0) begin
                        state_q         <= StWaitWr;
                        vnu_rd_finish_o <= 1'b1;
                    end else begin
                        phase_q <= phase_q - 8'd1;
                    end
                end
                // A write on the expiry cycle takes priority over the timeout.
                StWaitWr: begin
                    if (vnu_wr_i) begin
                        state_q            <= StIterUp;
                        vnu_init_load_en_o <= 1'b0;
                        vnu_rd_finish_o    <= 1'b0;
                    end else if (wd_expire) begin
                        state_q            <= StIdle;
                        wr_timeout_o       <= 1'b1;
                        busy_o             <= 1'b0;
                        vnu_init_load_en_o <= 1'b0;
                        vnu_rd_finish_o    <= 1'b0;
                    end
                end
                StIterUp: begin
                    iter_update_o <= ~iter_update_o;
                    iter_cnt_o    <= iter_next;
                    if (early_term || (iter_next == IterMaxW)) begin
                        state_q       <= StDone;
                        decode_done_o <= 1'b1;
                    end else begin
                        state_q <= StRead;
                        phase_q <= RdLoad;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vnu_iter_sched_fsm.sv
// Directed self-checking bench for vnu_iter_sched_fsm (default parameters).
module tb_vnu_iter_sched_fsm;

    logic       read_clk = 1'b0;
    logic       rstn = 1'b0;
    logic       decode_start_i = 1'b0;
    logic       vnu_wr_i = 1'b0;
`ifdef EARLY_TERM_EN
    logic       syndrome_zero_i = 1'b0;
`endif
    logic       vnu_init_load_en_o;
    logic       vnu_rd_finish_o;
    logic       iter_update_o;
    logic [3:0] iter_cnt_o;
    logic       busy_o;
    logic       decode_done_o;
    logic       wr_timeout_o;

    int n_tests = 0;
    int n_fail  = 0;
    int tog     = 0;
    int dones   = 0;
    int tog0;
    int dones0;
    logic upd_prev = 1'b0;

    vnu_iter_sched_fsm dut (
        .read_clk           (read_clk),
        .rstn               (rstn),
        .decode_start_i     (decode_start_i),
`ifdef EARLY_TERM_EN
        .syndrome_zero_i    (syndrome_zero_i),
`endif
        .vnu_wr_i           (vnu_wr_i),
        .vnu_init_load_en_o (vnu_init_load_en_o),
        .vnu_rd_finish_o    (vnu_rd_finish_o),
        .iter_update_o      (iter_update_o),
        .iter_cnt_o         (iter_cnt_o),
        .busy_o             (busy_o),
        .decode_done_o      (decode_done_o),
        .wr_timeout_o       (wr_timeout_o)
    );

    always #5 read_clk = ~read_clk;

    always @(negedge read_clk) begin
        if (iter_update_o !== upd_prev) tog++;
        upd_prev = iter_update_o;
        if (decode_done_o === 1'b1) dones++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge read_clk);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({vnu_init_load_en_o, vnu_rd_finish_o, iter_update_o, iter_cnt_o,
                    busy_o, decode_done_o, wr_timeout_o});
    endfunction

    // Leaves the bench at the first INIT_LOAD cycle.
    task automatic start_decode();
        decode_start_i = 1'b1;
        cyc(1);
        decode_start_i = 1'b0;
    endtask

    // Entered on the first WAIT_WR cycle; write returned on the second; leaves after ITER_UP.
    task automatic wait_wr(input logic syn);
        cyc(1);
        vnu_wr_i = 1'b1;
        cyc(1);
        vnu_wr_i = 1'b0;
`ifdef EARLY_TERM_EN
        syndrome_zero_i = syn;
`endif
        cyc(1);
`ifdef EARLY_TERM_EN
        syndrome_zero_i = 1'b0;
`endif
        if (syn) begin end
    endtask

    task automatic do_reset();
        @(negedge read_clk);
        rstn = 1'b0;
        cyc(2);
        rstn = 1'b1;
        cyc(1);
    endtask

    initial begin
        // Reset state
        cyc(2);
        chk("reset_outs", all_outs(), 0);
        rstn = 1'b1;
        cyc(1);
        chk("idle_busy", 32'(busy_o), 0);

        // First iteration timing
        start_decode();
        chk("load_en_c1", 32'(vnu_init_load_en_o), 1);
        chk("busy_c1", 32'(busy_o), 1);
        cyc(7);
        chk("load_en_c8", 32'(vnu_init_load_en_o), 1);
        cyc(1);
        chk("load_en_wait", 32'(vnu_init_load_en_o), 1);
        chk("no_finish_after_load", 32'(vnu_rd_finish_o), 0);
        cyc(2);
        vnu_wr_i = 1'b1;
        cyc(1);
        vnu_wr_i = 1'b0;
        chk("iterup_load_en", 32'(vnu_init_load_en_o), 0);
        chk("iterup_cnt", 32'(iter_cnt_o), 0);
        cyc(1);
        chk("iter1_update", 32'(iter_update_o), 1);
        chk("iter1_cnt", 32'(iter_cnt_o), 1);

        // Full run to ITER_MAX
        do_reset();
        tog0 = tog;
        dones0 = dones;
        start_decode();
        cyc(8);
        wait_wr(1'b0);
        for (int i = 2; i <= 10; i++) begin
            cyc(7);
            if (i == 5) chk("read_c8_finish", 32'(vnu_rd_finish_o), 0);
            cyc(1);
            if (i == 5) chk("read_done_finish", 32'(vnu_rd_finish_o), 1);
            wait_wr(1'b0);
        end
        chk("full_done", 32'(decode_done_o), 1);
        chk("full_cnt", 32'(iter_cnt_o), 10);
        chk("full_busy_in_done", 32'(busy_o), 1);
        cyc(1);
        chk("full_done_off", 32'(decode_done_o), 0);
        chk("full_busy_off", 32'(busy_o), 0);
        cyc(2);
        chk("full_toggles", 32'(tog - tog0), 10);
        chk("full_done_pulses", 32'(dones - dones0), 1);
        chk("full_cnt_hold", 32'(iter_cnt_o), 10);

        // Watchdog expiry
        dones0 = dones;
        start_decode();
        chk("restart_cnt_clr", 32'(iter_cnt_o), 0);
        cyc(8);
        cyc(63);
        chk("wd_c64_flag", 32'(wr_timeout_o), 0);
        chk("wd_c64_busy", 32'(busy_o), 1);
        cyc(1);
        chk("wd_flag", 32'(wr_timeout_o), 1);
        chk("wd_busy", 32'(busy_o), 0);
        chk("wd_load_en", 32'(vnu_init_load_en_o), 0);
        vnu_wr_i = 1'b1;
        cyc(1);
        vnu_wr_i = 1'b0;
        cyc(2);
        chk("wd_sticky", 32'(wr_timeout_o), 1);
        chk("wd_idle_ignores_wr", 32'(busy_o), 0);
        chk("wd_no_done", 32'(dones - dones0), 0);
        start_decode();
        chk("wd_clear_on_start", 32'(wr_timeout_o), 0);

        // Write on the expiry cycle wins
        cyc(8);
        cyc(63);
        vnu_wr_i = 1'b1;
        cyc(1);
        vnu_wr_i = 1'b0;
        chk("race_no_flag", 32'(wr_timeout_o), 0);
        chk("race_busy", 32'(busy_o), 1);
        cyc(1);
        chk("race_cnt", 32'(iter_cnt_o), 1);

        // Stray start/write during READ
        cyc(2);
        decode_start_i = 1'b1;
        vnu_wr_i = 1'b1;
        cyc(1);
        decode_start_i = 1'b0;
        vnu_wr_i = 1'b0;
        chk("stray_cnt", 32'(iter_cnt_o), 1);
        chk("stray_load_en", 32'(vnu_init_load_en_o), 0);
        cyc(4);
        chk("stray_read_len", 32'(vnu_rd_finish_o), 0);
        cyc(1);
        chk("stray_finish", 32'(vnu_rd_finish_o), 1);
        chk("stray_cnt2", 32'(iter_cnt_o), 1);

        // Reset during iteration 4 WAIT_WR
        do_reset();
        dones0 = dones;
        start_decode();
        cyc(8);
        wait_wr(1'b0);
        for (int i = 2; i <= 4; i++) begin
            cyc(8);
            if (i < 4) wait_wr(1'b0);
        end
        cyc(1);
        chk("pre_rst_cnt", 32'(iter_cnt_o), 3);
        chk("pre_rst_upd", 32'(iter_update_o), 1);
        #2 rstn = 1'b0;
        #1 chk("async_rst_outs", all_outs(), 0);
        cyc(1);
        rstn = 1'b1;
        chk("rst_no_done", 32'(dones - dones0), 0);
        cyc(1);
        start_decode();
        chk("post_rst_cnt", 32'(iter_cnt_o), 0);
        chk("post_rst_load", 32'(vnu_init_load_en_o), 1);
        cyc(8);
        wait_wr(1'b0);
        chk("post_rst_iter1", 32'(iter_cnt_o), 1);

`ifdef EARLY_TERM_EN
        // Early termination at iteration 3
        do_reset();
        start_decode();
        cyc(8);
        wait_wr(1'b0);
        cyc(8);
        wait_wr(1'b0);
        cyc(8);
        wait_wr(1'b1);
        chk("et_done", 32'(decode_done_o), 1);
        chk("et_cnt", 32'(iter_cnt_o), 3);
        cyc(1);
        chk("et_idle", 32'(busy_o), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
